uart_alu_bridge: RTL

- Framing and sequencing bridge between the UART byte modules (rx_module / tx_module) and the ALU.
- Collects multi-byte operands A and B plus an opcode byte from the receive stream, commits them to the ALU and pulses a start strobe.
- Captures the ALU result and serialises it back to the transmitter byte by byte.
- Generalised successor of the single-byte receive interface: operand width is parametric, the return path is handled, and stalled frames are aborted by timeout.

---
 rtl/uart_alu_pkg.sv | 33 +++
 rtl/uart_alu_bridge_byte_timeout.sv | 30 +++
 rtl/uart_alu_bridge.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART/ALU bridge: FSM states, ALU opcodes, frame sizing helpers.
// No logic of its own; latency and backpressure belong to the modules that import it.
package uart_alu_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_CAPT = 3'd4,
    S_TX   = 3'd5,
    S_TXW  = 3'd6
  } state_t;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

  // Bytes per operand; only meaningful when width_ok() holds.
  function automatic int unsigned nb_of(input int unsigned opw, input int unsigned dbit);
    return opw / dbit;
  endfunction

  function automatic bit width_ok(input int unsigned opw, input int unsigned dbit);
    return (dbit != 0) && (opw >= dbit) && ((opw % dbit) == 0);
  endfunction

endpackage

// File: rtl/uart_alu_bridge_byte_timeout.sv
// Inter-byte watchdog: counts enabled idle cycles, expire is combinational in the cycle the count hits TIMEOUT-1.
// No backpressure; the count restarts on clr, while disabled, and after expiry.
module byte_timeout
  import uart_alu_pkg::*;
#(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

  logic [TW-1:0] count;

  assign expire = en && (count == LIMIT);

  always_ff @(posedge clk) begin
    if (reset || clr || !en || expire) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_alu_bridge.sv
// Frames A/B/opcode bytes from the UART receiver into the ALU and streams the result back, LSB byte first.
// Opcode tick at t: alu_start at t+1, first tx_start at t+3; bytes arriving while executing/transmitting are dropped.
module uart_alu_bridge
  import uart_alu_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int OPW     = 16,
  parameter int OP_BITS = 6,
  parameter int TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_done_tick,
  input  logic [DBIT-1:0]    rx_data,
  input  logic [OPW-1:0]     alu_result,
  input  logic               tx_done_tick,
  output logic [OPW-1:0]     a,
  output logic [OPW-1:0]     b,
  output logic [OP_BITS-1:0] op,
  output logic               alu_start,
  output logic               tx_start,
  output logic [DBIT-1:0]    tx_data,
  output logic               busy,
  output logic               err_timeout
);

  localparam int NB = nb_of(OPW, DBIT);
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  if (!width_ok(OPW, DBIT) || (OP_BITS > DBIT) || (TIMEOUT < 2)) begin : g_param_check
    $error("uart_alu_bridge: illegal DBIT/OPW/OP_BITS/TIMEOUT combination");
  end

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [OPW-1:0]  sh_a;
  logic [OPW-1:0]  sh_b;
  logic [OPW-1:0]  tx_sr;
  logic            accept;
  logic            to_en;
  logic            to_expire;

  assign cnt_nxt = cnt + 1'b1;
  assign accept  = rx_done_tick && ((state == S_A) || (state == S_B) || (state == S_OP));
  assign to_en   = ((state == S_A) && (cnt != '0)) || (state == S_B) || (state == S_OP);

  byte_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .en     (to_en),
    .expire (to_expire)
  );

  // Outputs are registered on the transition into the state that owns them, so
  // alu_start is seen in S_EXEC and tx_start in S_TX.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_A;
      cnt         <= '0;
      sh_a        <= '0;
      sh_b        <= '0;
      tx_sr       <= '0;
      a           <= '0;
      b           <= '0;
      op          <= '0;
      alu_start   <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      alu_start   <= 1'b0;
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      if (to_expire && !accept) begin
        state       <= S_A;
        cnt         <= '0;
        sh_a        <= '0;
        sh_b        <= '0;
        busy        <= 1'b0;
        err_timeout <= 1'b1;
      end else begin
        unique case (state)
          S_A: if (rx_done_tick) begin
            sh_a[cnt*DBIT +: DBIT] <= rx_data;
            busy <= 1'b1;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= S_B;
            end else begin
              cnt <= cnt_nxt;
            end
          end
          S_B: if (rx_done_tick) begin
            sh_b[cnt*DBIT +: DBIT] <= rx_data;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= S_OP;
            end else begin
              cnt <= cnt_nxt;
            end
          end
          S_OP: if (rx_done_tick) begin
            a         <= sh_a;
            b         <= sh_b;
            op        <= rx_data[OP_BITS-1:0];
            alu_start <= 1'b1;
            state     <= S_EXEC;
          end
          S_EXEC: state <= S_CAPT;
          S_CAPT: begin
            tx_sr    <= alu_result;
            tx_data  <= alu_result[DBIT-1:0];
            tx_start <= 1'b1;
            cnt      <= '0;
            state    <= S_TX;
          end
          S_TX: state <= S_TXW;
          S_TXW: if (tx_done_tick) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              busy  <= 1'b0;
              state <= S_A;
            end else begin
              cnt      <= cnt_nxt;
              tx_data  <= tx_sr[cnt_nxt*DBIT +: DBIT];
              tx_start <= 1'b1;
              state    <= S_TX;
            end
          end
          default: state <= S_A;
        endcase
      end
    end
  end

endmodule
